conv_job_dispatcher: RTL and testbench

Initiator side of the convolution start/done handshake. Accepts (X, Y, Z) address-triple jobs from a host into a small FIFO, drives start and X/Y/Z into the convolution engine, and waits for done. It then retires the job and issues the next one. Sits between the host/testbench layer and the convolution core, replacing hand-timed start pulses.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_job_fifo.sv | 61 ++++++
 rtl/conv_job_dispatcher.sv | 136 +++++++++++++
 tb/tb_conv_job_dispatcher.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution job dispatcher.
//   ADDR_W  : default width of each X/Y/Z job operand
//   JOB_W   : width of one packed {X, Y, Z} job as stored in the FIFO
//   state_t : dispatcher FSM encoding
package conv_pkg;

    localparam int ADDR_W = 7;
    localparam int JOB_W  = 3 * ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/conv_job_fifo.sv
// Synchronous job FIFO, DEPTH entries of WIDTH bits (DEPTH a power of two).
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   push, wdata   write request and data (ignored while full)
//   pop, rdata    read request (ignored while empty); rdata shows the head
//   full, empty   occupancy flags
//   count         current occupancy, 0..DEPTH
module conv_job_fifo
    import conv_pkg::*;
#(
    parameter int WIDTH = JOB_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/conv_job_dispatcher.sv
// Initiator side of the convolution start/done handshake. Host jobs
// (X, Y, Z) are queued in a FIFO; each is issued to the core with a
// START_LEN-cycle start pulse, then the block waits for done (bounded by
// TIMEOUT) and for done to fall again before issuing the next job.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   job_valid/job_ready      host job handshake, job_x/y/z operands
//   conv_start, conv_x/y/z   start and operands to the core
//   conv_done                level done from the core
//   busy, queue_count        activity / FIFO occupancy
//   jobs_done                retired-job counter (wraps)
//   timeout_err, clear_err   sticky timeout flag and its clear
module conv_job_dispatcher
    import conv_pkg::*;
#(
    parameter int ADDR_W    = conv_pkg::ADDR_W,
    parameter int DEPTH     = 4,
    parameter int START_LEN = 3,
    parameter int TIMEOUT   = 8000,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [ADDR_W-1:0]        job_x,
    input  logic [ADDR_W-1:0]        job_y,
    input  logic [ADDR_W-1:0]        job_z,
    output logic                     conv_start,
    output logic [ADDR_W-1:0]        conv_x,
    output logic [ADDR_W-1:0]        conv_y,
    output logic [ADDR_W-1:0]        conv_z,
    input  logic                     conv_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [CNT_W-1:0]         jobs_done,
    output logic                     timeout_err,
    input  logic                     clear_err
);

    localparam int JW = 3 * ADDR_W;
    localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] START_LAST = SW'(START_LEN - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   scnt;
    logic [TW-1:0]   tcnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            done_hit;
    logic            to_hit;
    logic [JW-1:0]   head;

    // Ready comes from the pre-pop count: a full FIFO never accepts,
    // even in a cycle where the FSM pops.
    assign job_ready  = ~fifo_full;
    assign conv_start = (state == ST_START);
    assign busy       = (state != ST_IDLE) | ~fifo_empty;

    conv_job_fifo #(
        .WIDTH (JW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (job_valid & job_ready),
        .wdata ({job_x, job_y, job_z}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        done_hit = 1'b0;
        to_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (scnt == START_LAST) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes priority over a timeout in the same cycle
                if (conv_done) begin
                    done_hit = 1'b1;
                    state_nx = ST_DRAIN;
                end else if (tcnt == TO_LAST) begin
                    to_hit   = 1'b1;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // a level-held done must fall before the next job starts
                if (!conv_done) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            scnt        <= '0;
            tcnt        <= '0;
            conv_x      <= '0;
            conv_y      <= '0;
            conv_z      <= '0;
            jobs_done   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) {conv_x, conv_y, conv_z} <= head;
            // counters run only in their own state and restart from zero
            scnt <= (state == ST_START) ? scnt + 1'b1 : '0;
            tcnt <= (state == ST_WAIT)  ? tcnt + 1'b1 : '0;
            if (done_hit) jobs_done <= jobs_done + 1'b1;
            if (to_hit)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_job_dispatcher.sv
module tb_conv_job_dispatcher;

    localparam int ADDR_W    = 7;
    localparam int DEPTH     = 4;
    localparam int START_LEN = 3;
    localparam int TIMEOUT   = 8000;
    localparam int CNT_W     = 8;

    logic               clk;
    logic               rst;
    logic               job_valid;
    logic               job_ready;
    logic [ADDR_W-1:0]  job_x, job_y, job_z;
    logic               conv_start;
    logic [ADDR_W-1:0]  conv_x, conv_y, conv_z;
    logic               conv_done;
    logic               busy;
    logic [$clog2(DEPTH):0] queue_count;
    logic [CNT_W-1:0]   jobs_done;
    logic               timeout_err;
    logic               clear_err;

    conv_job_dispatcher #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .START_LEN (START_LEN),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_z       (job_z),
        .conv_start  (conv_start),
        .conv_x      (conv_x),
        .conv_y      (conv_y),
        .conv_z      (conv_z),
        .conv_done   (conv_done),
        .busy        (busy),
        .queue_count (queue_count),
        .jobs_done   (jobs_done),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] x;
        logic [ADDR_W-1:0] y;
        logic [ADDR_W-1:0] z;
    } job_t;

    typedef struct {
        logic [ADDR_W-1:0] x;
        logic [ADDR_W-1:0] y;
        logic [ADDR_W-1:0] z;
        int                delay;
        int                hold;
        int                exp_inc;
    } vec_t;

    job_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_done = 0;
    int   rise_cyc = 0;
    int   core_en    = 1;
    int   core_delay = 1;
    int   core_hold  = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Core model: done rises core_delay cycles after start falls, held core_hold cycles.
    initial begin
        logic prev_c;
        prev_c    = 1'b0;
        conv_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_c && !conv_start && core_en != 0) begin
                repeat (core_delay - 1) @(negedge clk);
                conv_done = 1'b1;
                repeat (core_hold) @(negedge clk);
                conv_done = 1'b0;
            end
            prev_c = conv_start;
        end
    end

    // Monitor: every start pulse pops the scoreboard and checks operands and length.
    initial begin
        logic prev_s;
        int   slen;
        job_t e;
        prev_s = 1'b0;
        slen   = 0;
        forever begin
            @(negedge clk);
            if (conv_start && !prev_s) begin
                rise_cyc = cyc;
                slen     = 1;
                chk("done_low_at_start", conv_done, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_start_sb_size", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("conv_x", conv_x, e.x);
                    chk("conv_y", conv_y, e.y);
                    chk("conv_z", conv_z, e.z);
                end
            end else if (conv_start) begin
                slen++;
            end else if (prev_s) begin
                chk("start_len", slen, START_LEN);
            end
            prev_s = conv_start;
        end
    end

    task automatic push_job(input logic [ADDR_W-1:0] x, y, z, output int pcyc);
        int   guard;
        job_t j;
        guard = 0;
        @(negedge clk);
        job_valid = 1'b1;
        job_x = x; job_y = y; job_z = z;
        while (!job_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        pcyc = cyc;
        if (job_ready) begin
            j.x = x; j.y = y; j.z = z;
            sb.push_back(j);
            @(posedge clk);
        end else begin
            chk("push_accept", job_ready, 1);
            job_valid = 1'b0;
        end
    endtask

    task automatic release_valid();
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || conv_done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic wait_start_fall(output int ok);
        int g;
        g = 0;
        @(negedge clk);
        while (!conv_start && g < 20000) begin @(negedge clk); g++; end
        while (conv_start && g < 20000) begin @(negedge clk); g++; end
        ok = (g < 20000) ? 1 : 0;
    endtask

    initial begin
        vec_t tbl[5];
        int   pc;
        int   ok;
        int   n;

        tbl[0] = '{x: 7'd0,   y: 7'd0,   z: 7'd0,   delay: 1,  hold: 1, exp_inc: 1};
        tbl[1] = '{x: 7'd127, y: 7'd127, z: 7'd127, delay: 3,  hold: 2, exp_inc: 1};
        tbl[2] = '{x: 7'd1,   y: 7'd2,   z: 7'd4,   delay: 10, hold: 5, exp_inc: 1};
        tbl[3] = '{x: 7'd100, y: 7'd27,  z: 7'd64,  delay: 1,  hold: 3, exp_inc: 1};
        tbl[4] = '{x: 7'd42,  y: 7'd85,  z: 7'd21,  delay: 50, hold: 1, exp_inc: 1};

        rst = 1'b0; job_valid = 1'b0; clear_err = 1'b0;
        job_x = '0; job_y = '0; job_z = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_conv_x", conv_x, 0);
        chk("rst_conv_y", conv_y, 0);
        chk("rst_conv_z", conv_z, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_queue_count", queue_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_job_ready", job_ready, 1);
        rst = 1'b1;

        // Single job with a long core response; start rises 2 cycles after the job is offered
        core_delay = 6600; core_hold = 1;
        push_job(7'd5, 7'd71, 7'd83, pc);
        release_valid();
        wait_idle(20000, "single_idle");
        exp_done++;
        chk("single_latency", rise_cyc - pc, 2);
        chk("single_jobs_done", jobs_done, exp_done % 256);
        chk("single_hold_x", conv_x, 5);
        chk("single_hold_z", conv_z, 83);

        // Table of single jobs with varied core timing
        for (int i = 0; i < 5; i++) begin
            core_delay = tbl[i].delay;
            core_hold  = tbl[i].hold;
            push_job(tbl[i].x, tbl[i].y, tbl[i].z, pc);
            release_valid();
            wait_idle(20000, "tbl_idle");
            exp_done += tbl[i].exp_inc;
            chk("tbl_jobs_done", jobs_done, exp_done % 256);
            chk("tbl_hold_x", conv_x, tbl[i].x);
            chk("tbl_hold_y", conv_y, tbl[i].y);
            chk("tbl_hold_z", conv_z, tbl[i].z);
        end

        // Five back-to-back jobs: first is popped at once, the next four fill the FIFO
        core_delay = 2; core_hold = 1;
        for (int i = 0; i < 5; i++)
            push_job(7'(10 + i), 7'(20 + i), 7'(30 + i), pc);
        release_valid();
        chk("b2b_queue_full", queue_count, 4);
        chk("b2b_ready_low", job_ready, 0);
        wait_idle(20000, "b2b_idle");
        exp_done += 5;
        chk("b2b_jobs_done", jobs_done, exp_done % 256);
        chk("b2b_queue_empty", queue_count, 0);

        // Done held high for 10 cycles: one increment per job, next start after done falls
        core_delay = 3; core_hold = 10;
        push_job(7'd11, 7'd22, 7'd33, pc);
        push_job(7'd44, 7'd55, 7'd66, pc);
        release_valid();
        wait_idle(20000, "hold_idle");
        exp_done += 2;
        chk("hold_jobs_done", jobs_done, exp_done % 256);

        // Timeout: first job gets no done (clear_err held, set wins); second completes
        core_en = 0; core_delay = 4; core_hold = 1; clear_err = 1'b1;
        push_job(7'd3, 7'd6, 7'd9, pc);
        push_job(7'd12, 7'd15, 7'd18, pc);
        release_valid();
        wait_start_fall(ok);
        chk("to_start_fall_seen", ok, 1);
        n = 0;
        while (!timeout_err && n < TIMEOUT + 10) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_err_set_wins", timeout_err, 1);
        clear_err = 1'b0;
        core_en = 1;
        chk("to_jobs_unchanged", jobs_done, exp_done % 256);
        wait_idle(20000, "to_idle");
        exp_done += 1;
        chk("to_next_job_done", jobs_done, exp_done % 256);
        chk("to_err_sticky", timeout_err, 1);
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
        chk("to_err_cleared", timeout_err, 0);

        // Reset in WAIT with two jobs queued
        core_delay = 30; core_hold = 2;
        push_job(7'd70, 7'd71, 7'd72, pc);
        push_job(7'd73, 7'd74, 7'd75, pc);
        push_job(7'd76, 7'd77, 7'd78, pc);
        release_valid();
        wait_start_fall(ok);
        chk("rw_start_fall_seen", ok, 1);
        repeat (5) @(negedge clk);
        chk("rw_queue_before", queue_count, 2);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_conv_start", conv_start, 0);
        chk("rw_queue_count", queue_count, 0);
        chk("rw_busy", busy, 0);
        chk("rw_job_ready", job_ready, 1);
        chk("rw_conv_x", conv_x, 0);
        chk("rw_conv_y", conv_y, 0);
        chk("rw_conv_z", conv_z, 0);
        chk("rw_jobs_done", jobs_done, 0);
        rst = 1'b1;
        sb.delete();
        exp_done = 0;
        repeat (40) @(negedge clk);
        core_delay = 2; core_hold = 1;
        push_job(7'd90, 7'd91, 7'd92, pc);
        release_valid();
        wait_idle(20000, "rw_after_idle");
        exp_done += 1;
        chk("rw_after_jobs_done", jobs_done, exp_done % 256);

        // Counter wrap: bring the total to 256 retired jobs
        core_delay = 1; core_hold = 1;
        for (int i = exp_done; i < 256; i++)
            push_job(7'(i), 7'(i + 1), 7'(i + 2), pc);
        release_valid();
        wait_idle(20000, "wrap_idle");
        exp_done = 256;
        chk("wrap_jobs_done", jobs_done, exp_done % 256);
        chk("wrap_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
